// File: rtl/pp_tree_pkg.sv
// Shared limits and elaboration helpers for the pp_tree_pipe partial-product reduction tree.
package pp_tree_pkg;

  localparam int W_MIN = 8;
  localparam int W_MAX = 128;
  localparam int N_MIN = 4;
  localparam int N_MAX = 64;

  // Number of 4:2 compressor stages needed to reduce n rows down to two.
  function automatic int num_stages(input int n);
    return $clog2(n) - 1;
  endfunction

  // Index of the first compressor of stage k when all stages are packed
  // back to back: stage 0 has n/4 compressors, stage 1 has n/8, and so on.
  function automatic int stage_offset(input int n, input int k);
    return (n / 2) - (n >> (k + 1));
  endfunction

  function automatic bit params_legal(input int w, input int n, input int tag_w);
    return (w >= W_MIN) && (w <= W_MAX) &&
           (n >= N_MIN) && (n <= N_MAX) && ((n & (n - 1)) == 0) &&
           (tag_w >= 1);
  endfunction

endpackage

// File: rtl/pp_tree_pipe_compressor42_row.sv
// compressor42_row: combinational 4:2 row compressor; carry_o has weight 2 and its MSB
// is dropped by whoever shifts it, the internal carry-out of the top bit is discarded.
module compressor42_row #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] s1;
  logic [W-1:0] cin;

  always_comb begin
    s1      = a_i ^ b_i ^ c_i;
    // The first adder's carry ripples exactly one column: bit i feeds bit i+1.
    cin     = {(a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0]) |
               (b_i[W-2:0] & c_i[W-2:0]), 1'b0};
    sum_o   = s1 ^ d_i ^ cin;
    carry_o = (s1 & d_i) | (s1 & cin) | (d_i & cin);
  end

endmodule

// File: rtl/pp_tree_pipe.sv
// pp_tree_pipe: pipelined 4:2 compressor tree reducing N operands to a sum/carry pair,
// one register slice per stage with valid/ready flow control. Optional final adder: PP_TREE_PIPE_FINAL_CPA_EN.
module pp_tree_pipe
  import pp_tree_pkg::*;
#(
  parameter int W     = 64,
  parameter int N     = 16,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_pp,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic [W-1:0]       out_carry,
  output logic [TAG_W-1:0]   out_tag
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
  ,
  output logic [W-1:0]       out_result
`endif
);

  localparam int S    = num_stages(N);
  localparam int NROW = N / 2 - 1;
  localparam int LAST = NROW - 1;
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
  localparam int L = S + 1;
`else
  localparam int L = S;
`endif

  if (!params_legal(W, N, TAG_W)) begin : g_param_check
    $error("pp_tree_pipe: illegal parameters W=%0d N=%0d TAG_W=%0d", W, N, TAG_W);
  end

  logic [L-1:0]              valid_q;
  logic [L-1:0]              adv;
  logic [L-1:0]              vin;
  logic [L-1:0]              load;
  logic [L-1:0][TAG_W-1:0]   tag_q;

  logic [NROW-1:0][W-1:0]    a_w, b_w, c_w, d_w;
  logic [NROW-1:0][W-1:0]    sum_w, carry_w;
  logic [NROW-1:0][W-1:0]    sum_q, carry_q;
  logic [NROW-1:0]           row_load;
  logic [NROW-1:0]           unused_carry_msb;

  // Compressor (k, j) lives at flat index stage_offset(N, k) + j.
  for (genvar k = 0; k < S; k++) begin : g_stage
    for (genvar j = 0; j < (N >> (k + 2)); j++) begin : g_row
      localparam int IDX = stage_offset(N, k) + j;
      if (k == 0) begin : g_first
        assign a_w[IDX] = in_pp[(4*j+0)*W +: W];
        assign b_w[IDX] = in_pp[(4*j+1)*W +: W];
        assign c_w[IDX] = in_pp[(4*j+2)*W +: W];
        assign d_w[IDX] = in_pp[(4*j+3)*W +: W];
      end else begin : g_later
        localparam int PA = stage_offset(N, k - 1) + 2 * j;
        localparam int PB = PA + 1;
        assign a_w[IDX] = sum_q[PA];
        assign b_w[IDX] = {carry_q[PA][W-2:0], 1'b0};
        assign c_w[IDX] = sum_q[PB];
        assign d_w[IDX] = {carry_q[PB][W-2:0], 1'b0};
      end
      assign row_load[IDX] = load[k];

      compressor42_row #(.W(W)) u_cmp (
        .a_i     (a_w[IDX]),
        .b_i     (b_w[IDX]),
        .c_i     (c_w[IDX]),
        .d_i     (d_w[IDX]),
        .sum_o   (sum_w[IDX]),
        .carry_o (carry_w[IDX])
      );
    end
  end

  // Shifting a carry row left pushes its MSB past the row width.
  for (genvar i = 0; i < NROW; i++) begin : g_msb
    assign unused_carry_msb[i] = carry_q[i][W-1];
  end

  always_comb begin
    logic downstream;
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    adv        = '0;
    vin        = '0;
    downstream = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      adv[k]     = !valid_q[k] || downstream;
      downstream = adv[k];
    end
    vin[0] = in_valid;
    for (int k = 1; k < L; k++) begin
      vin[k] = valid_q[k-1];
    end
    load = adv & vin;
  end

  // NOTE: sequential state uses non-blocking assignments so every slice samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data rows are cleared as well so the outputs read zero straight out of reset.
      valid_q <= '0;
      tag_q   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (adv[k]) valid_q[k] <= vin[k];
      end
      if (load[0]) tag_q[0] <= in_tag;
      for (int k = 1; k < L; k++) begin
        if (load[k]) tag_q[k] <= tag_q[k-1];
      end
      for (int i = 0; i < NROW; i++) begin
        if (row_load[i]) begin
          sum_q[i]   <= sum_w[i];
          carry_q[i] <= carry_w[i];
        end
      end
    end
  end

  assign in_ready  = adv[0] && rst_n;
  assign out_valid = valid_q[L-1];
  assign out_tag   = tag_q[L-1];

`ifdef PP_TREE_PIPE_FINAL_CPA_EN
  logic [W-1:0] cpa_sum_q, cpa_carry_q, cpa_result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpa_sum_q    <= '0;
      cpa_carry_q  <= '0;
      cpa_result_q <= '0;
    end else if (load[L-1]) begin
      cpa_sum_q    <= sum_q[LAST];
      cpa_carry_q  <= carry_q[LAST];
      cpa_result_q <= sum_q[LAST] + {carry_q[LAST][W-2:0], 1'b0};
    end
  end

  assign out_sum    = cpa_sum_q;
  assign out_carry  = cpa_carry_q;
  assign out_result = cpa_result_q;
`else
  assign out_sum   = sum_q[LAST];
  assign out_carry = carry_q[LAST];
`endif

endmodule

// File: tb/tb_pp_tree_pipe.sv
// Self-checking bench for pp_tree_pipe: arithmetic reference model with an in-order queue,
// directed corner cases, backpressure, mid-flight reset and randomized traffic.
module tb_pp_tree_pipe;

  localparam int W   = 64;
  localparam int N   = 16;
  localparam int TW  = 8;
  localparam int SW  = 16;
  localparam int SN  = 4;
  localparam int STW = 4;
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
  localparam int LAT  = 4;
  localparam int SLAT = 2;
`else
  localparam int LAT  = 3;
  localparam int SLAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0]   in_pp;
  logic [TW-1:0]    in_tag, out_tag;
  logic [W-1:0]     out_sum, out_carry;
  logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [SN*SW-1:0] s_in_pp;
  logic [STW-1:0]   s_in_tag, s_out_tag;
  logic [SW-1:0]    s_out_sum, s_out_carry;
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
  logic [W-1:0]     out_result;
  logic [SW-1:0]    s_out_result;
`endif

  always #5 clk = ~clk;

  pp_tree_pipe #(.W(W), .N(N), .TAG_W(TW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag)
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
    , .out_result(out_result)
`endif
  );

  pp_tree_pipe #(.W(SW), .N(SN), .TAG_W(STW)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pp(s_in_pp), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_carry(s_out_carry), .out_tag(s_out_tag)
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
    , .out_result(s_out_result)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  int emitted     = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]  value;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] pp);
    logic [W-1:0] acc = '0;
    for (int i = 0; i < N; i++) acc += pp[i*W +: W];
    return acc;
  endfunction

  function automatic logic [N*W-1:0] rand_pp();
    logic [N*W-1:0] p;
    for (int i = 0; i < N * W / 32; i++) p[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 7) == 0) p = '1;
    return p;
  endfunction

  // Scoreboard: pops on every emit, pushes on every accept, checks hold-while-stalled.
  logic          stall_seen = 1'b0;
  logic [W-1:0]  held_sum, held_carry;
  logic [TW-1:0] held_tag;
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] recon;
    if (!rst_n) begin
      exp_q.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_valid", out_valid, 1);
        check("stall_sum", out_sum, held_sum);
        check("stall_carry", out_carry, held_carry);
        check("stall_tag", out_tag, held_tag);
      end
      stall_seen = out_valid && !out_ready;
      held_sum   = out_sum;
      held_carry = out_carry;
      held_tag   = out_tag;
      if (out_valid && out_ready) begin
        check("emit_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e     = exp_q.pop_front();
          recon = out_sum + {out_carry[W-2:0], 1'b0};
          check("recon", recon, e.value);
          check("tag", out_tag, e.tag);
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
          check("result", out_result, e.value);
`endif
          emitted++;
        end
      end
      if (in_valid && in_ready) begin
        e.value = ref_sum(in_pp);
        e.tag   = in_tag;
        exp_q.push_back(e);
      end
    end
  end

  task automatic cycle(input logic rst, input logic v, input logic [N*W-1:0] pp,
                       input logic [TW-1:0] tag, input logic r, output logic acc);
    @(posedge clk);
    #1;
    rst_n     = rst;
    in_valid  = v;
    in_pp     = pp;
    in_tag    = tag;
    out_ready = r;
    @(negedge clk);
    #1;
    acc = v && in_ready;
  endtask

  task automatic send_measure(input string name, input logic [N*W-1:0] pp,
                              input logic [TW-1:0] tag, input logic [W-1:0] exp_recon);
    logic         acc;
    int           lat;
    logic [W-1:0] recon;
    cycle(1'b1, 1'b1, pp, tag, 1'b1, acc);
    check({name, "_accept"}, acc, 1);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, '0, '0, 1'b1, acc);
      lat++;
      if (out_valid) break;
    end
    recon = out_sum + {out_carry[W-2:0], 1'b0};
    check({name, "_latency"}, lat, LAT);
    check({name, "_recon"}, recon, exp_recon);
    check({name, "_tag"}, out_tag, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic           acc, saw_low;
    logic [N*W-1:0] pp;
    logic [N*W-1:0] bp_pp[10];
    int             idx, snap, lat;
    logic           have;
    logic [TW-1:0]  tag;
    logic [SW-1:0]  s_recon;

    rst_n = 1'b0; in_valid = 1'b0; in_pp = '0; in_tag = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_pp = '0; s_in_tag = '0; s_out_ready = 1'b1;

    repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_carry", out_carry, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 0);
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
    check("reset_out_result", out_result, 0);
`endif
    cycle(1'b1, 1'b0, '0, '0, 1'b1, acc);
    check("ready_after_reset", in_ready, 1);

    for (int k = 0; k < N; k++) pp[k*W +: W] = 64'd1;
    check("model_ones", ref_sum(pp), 64'd16);
    send_measure("ones", pp, 8'hA5, 64'd16);

    pp = '1;
    check("model_wrap", ref_sum(pp), 64'hFFFF_FFFF_FFFF_FFF0);
    send_measure("wrap", pp, 8'h3C, 64'hFFFF_FFFF_FFFF_FFF0);

    for (int k = 0; k < N; k++) pp[k*W +: W] = 64'(k);
    check("model_ramp", ref_sum(pp), 64'd120);
    send_measure("ramp", pp, 8'h5A, 64'd120);
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
    check("ramp_out_result", out_result, 64'd120);
`endif

    // Backpressure: ten sets back to back, consumer stalls on cycles 4..9.
    for (int i = 0; i < 10; i++) bp_pp[i] = rand_pp();
    idx = 0; saw_low = 1'b0; snap = emitted;
    for (int c = 0; c < 60 && (idx < 10 || exp_q.size() > 0); c++) begin
      cycle(1'b1, idx < 10, (idx < 10) ? bp_pp[idx] : '0, TW'(8'h10 + idx),
            !(c >= 4 && c <= 9), acc);
      if (!in_ready) saw_low = 1'b1;
      if (acc) idx++;
    end
    check("bp_ready_dropped", saw_low, 1);
    check("bp_all_accepted", idx, 10);
    check("bp_all_emitted", emitted - snap, 10);
    check("bp_model_drained", exp_q.size(), 0);

    // Reset with two sets in flight.
    cycle(1'b1, 1'b1, rand_pp(), 8'hE1, 1'b1, acc);
    check("mid_accept_0", acc, 1);
    cycle(1'b1, 1'b1, rand_pp(), 8'hE2, 1'b1, acc);
    check("mid_accept_1", acc, 1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("mid_ready_in_reset", in_ready, 0);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, acc);
    check("mid_out_valid_cleared", out_valid, 0);
    check("mid_ready_after", in_ready, 1);
    snap = emitted;
    repeat (8) cycle(1'b1, 1'b0, '0, '0, 1'b1, acc);
    check("mid_nothing_emitted", emitted, snap);

    // Randomized traffic with random backpressure.
    have = 1'b0; pp = '0; tag = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!have) begin
        pp = rand_pp(); tag = TW'($urandom); have = 1'b1;
      end
      cycle(1'b1, have && ($urandom_range(0, 9) < 7), pp, tag, $urandom_range(0, 3) != 0, acc);
      if (acc) have = 1'b0;
    end
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) cycle(1'b1, 1'b0, '0, '0, 1'b1, acc);
    check("random_drained", exp_q.size(), 0);

    // Smallest tree: N=4, W=16, a single compressor stage.
    @(posedge clk);
    #1;
    s_in_valid = 1'b1;
    s_in_pp    = {16'h0002, 16'h0001, 16'h8000, 16'h8000};
    s_in_tag   = 4'h9;
    @(negedge clk);
    #1;
    check("small_accept", s_in_ready, 1);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s_recon = s_out_sum + {s_out_carry[SW-2:0], 1'b0};
    check("small_latency", lat, SLAT);
    check("small_recon", s_recon, 16'h0003);
    check("small_tag", s_out_tag, 4'h9);
`ifdef PP_TREE_PIPE_FINAL_CPA_EN
    check("small_result", s_out_result, 16'h0003);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
